sigmoid_lut_fetcher: RTL and testbench
======================================

Name: sigmoid_lut_fetcher

Overview:
Front end of the piecewise-linear sigmoid unit in each LSTM gate layer. It takes a signed fixed-point activation and splits it into a table segment index and a fractional remainder. It then reads the two bracketing entries from the external sigmoid table ROM and presents base, next_data, change and remaining to the downstream linear interpolator. It produces the operands that the interpolator consumes.

Parameters:
DATA_WIDTH, 8, width of the activation input, the table entries and all operand outputs (signed two's complement).
FRAC_BITS, 4, number of fractional bits in the input; this is also the interpolator's right-shift amount.
ADDR_WIDTH, 5, ROM address width; must hold 2^(DATA_WIDTH-FRAC_BITS)+1 entries (17 by default).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  x is valid
in_ready  output  1  block can accept x
x  input  DATA_WIDTH  signed activation value
rom_en  output  1  ROM read enable
rom_addr  output  ADDR_WIDTH  ROM read address
rom_data  input  DATA_WIDTH  ROM read data; valid exactly 1 cycle after rom_en is sampled high
out_valid  output  1  operand set valid
out_ready  input  1  interpolator accepts the operand set
base  output  DATA_WIDTH  table[idx]
next_data  output  DATA_WIDTH  table[idx+1]
change  output  DATA_WIDTH  next_data - base, wrapped to DATA_WIDTH
remaining  output  DATA_WIDTH  fraction x[FRAC_BITS-1:0], zero-extended

Behaviour:
- Only the clock domain clk is used. rst is synchronous and active-high, and it overrides every other input.
- Reset values: state=IDLE, in_ready=1, rom_en=0, rom_addr=0, out_valid=0, and base, next_data, change and remaining all 0.
- Index arithmetic: idx = (x >>> FRAC_BITS) + 2^(DATA_WIDTH-FRAC_BITS-1). This maps -128..127 onto 0..15. idx is never clamped; the next entry is idx+1, which is at most 16.
- State machine. All outputs are registered; "cycle n" means the cycle after the nth rising edge.
  - IDLE: in_ready=1. When in_valid&in_ready: latch idx and the fraction, drive rom_en=1 and rom_addr=idx, then go to RD_NEXT.
  - RD_NEXT: in_ready=0, rom_en=1, rom_addr=idx+1. Capture rom_data into base. Go to CAPTURE.
  - CAPTURE: rom_en=0. Capture rom_data into next_data. Register change = rom_data - base and load remaining. Set out_valid=1. Go to HOLD.
  - HOLD: out_valid=1, and base, next_data, change and remaining are held stable. When out_ready=1: set out_valid=0, in_ready=1, and go to IDLE.
- Latency: from the accept edge, out_valid rises 3 cycles later. Minimum initiation interval is 4 cycles, reached when out_ready is already high in HOLD.
- in_ready is high only in IDLE. in_valid outside IDLE is ignored; there is no skid buffer.
- rom_en is high in exactly 2 consecutive cycles per transaction, with addresses idx then idx+1.
- Output operands stay constant from the rise of out_valid to the handshake edge, however long out_ready stays low.
- After the handshake, the operand outputs keep their last values; only out_valid drops.
- rst in any state: the next cycle shows reset values. Any in-flight ROM data is discarded, and the next ROM read starts only after a new accept.
- If out_ready is high in the same cycle out_valid first rises, the handshake completes on that edge.
- change uses modular subtraction, for example base=0x7F and next=0x80 gives 0x01.

Test Plan:
- Reset, then x=0x00 with table[8]=0x40 and table[9]=0x48 -> rom_addr 8 then 9 on consecutive cycles. Out at accept+3: base=0x40, next=0x48, change=0x08, remaining=0x00.
- x=0x80 (-128) -> addr 0 then 1, remaining=0. x=0x7F -> addr 15 then 16, remaining=0x0F. Neither case may wrap the address.
- x=0x2B with table[10]=0x50 and table[11]=0x5C -> base=0x50, change=0x0C, remaining=0x0B. Feeding this to the interpolator yields 0x58.
- Backpressure: out_ready held 0 for 10 cycles -> out_valid stays 1 with outputs constant and in_ready stays 0. A second in_valid during this time is ignored. Raising out_ready gives in_ready=1 on the next cycle.
- Back-to-back: in_valid and out_ready held high -> one transaction every 4 cycles, with exactly 2 rom_en pulses each.
- rst asserted in RD_NEXT and then in HOLD -> next cycle shows all outputs 0, in_ready=1, and no further rom_en until a new accept.

Source files
------------

// File: rtl/sigmoid_lut_fetcher_if.sv
// Handshake and ROM bus bundle for the sigmoid LUT fetcher.
// master = environment (producer, ROM, interpolator); slave = the fetcher.
interface sigmoid_lut_fetcher_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] x;
  logic                  rom_en;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] base;
  logic [DATA_WIDTH-1:0] next_data;
  logic [DATA_WIDTH-1:0] change;
  logic [DATA_WIDTH-1:0] remaining;

  modport master (
    output in_valid, x, rom_data, out_ready,
    input  in_ready, rom_en, rom_addr, out_valid,
           base, next_data, change, remaining
  );

  modport slave (
    input  in_valid, x, rom_data, out_ready,
    output in_ready, rom_en, rom_addr, out_valid,
           base, next_data, change, remaining
  );
endinterface

// File: rtl/sigmoid_lut_fetcher.sv
// Splits a signed fixed-point activation into table index and fraction, reads the
// two bracketing sigmoid table entries and presents interpolation operands.
module sigmoid_lut_fetcher #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 4,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  sigmoid_lut_fetcher_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD_NEXT, CAPTURE, HOLD} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [FRAC_BITS-1:0]  frac_q, frac_d;
  logic                  in_ready_q, in_ready_d;
  logic                  rom_en_q, rom_en_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0] next_q, next_d;
  logic [DATA_WIDTH-1:0] change_q, change_d;
  logic [DATA_WIDTH-1:0] remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0] idx_in;

  // Adding the half-range bias to the signed integer part is the same as
  // inverting its sign bit, so -128..127 lands on 0..15 without an adder.
  assign idx_in = ADDR_WIDTH'({~bus.x[DATA_WIDTH-1], bus.x[DATA_WIDTH-2:FRAC_BITS]});

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    idx_d       = idx_q;
    frac_d      = frac_q;
    in_ready_d  = in_ready_q;
    rom_en_d    = rom_en_q;
    rom_addr_d  = rom_addr_q;
    out_valid_d = out_valid_q;
    base_d      = base_q;
    next_d      = next_q;
    change_d    = change_q;
    remaining_d = remaining_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          idx_d      = idx_in;
          frac_d     = bus.x[FRAC_BITS-1:0];
          in_ready_d = 1'b0;
          rom_en_d   = 1'b1;
          rom_addr_d = idx_in;
          state_d    = RD_NEXT;
        end
      end
      RD_NEXT: begin
        // The top index is 15, so idx+1 = 16 still fits the 17-entry table.
        rom_addr_d = idx_q + ADDR_WIDTH'(1);
        base_d     = bus.rom_data;
        state_d    = CAPTURE;
      end
      CAPTURE: begin
        rom_en_d    = 1'b0;
        next_d      = bus.rom_data;
        change_d    = bus.rom_data - base_q;
        remaining_d = DATA_WIDTH'(frac_q);
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      frac_q      <= '0;
      in_ready_q  <= 1'b1;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      out_valid_q <= 1'b0;
      base_q      <= '0;
      next_q      <= '0;
      change_q    <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frac_q      <= frac_d;
      in_ready_q  <= in_ready_d;
      rom_en_q    <= rom_en_d;
      rom_addr_q  <= rom_addr_d;
      out_valid_q <= out_valid_d;
      base_q      <= base_d;
      next_q      <= next_d;
      change_q    <= change_d;
      remaining_q <= remaining_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.rom_en    = rom_en_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.base      = base_q;
  assign bus.next_data = next_q;
  assign bus.change    = change_q;
  assign bus.remaining = remaining_q;

endmodule

// File: tb/tb_sigmoid_lut_fetcher.sv
// Bench for sigmoid_lut_fetcher: directed corner cases plus random activations,
// checked against an arithmetic model of index/fraction split and table lookup.
module tb_sigmoid_lut_fetcher;
  localparam int DW      = 8;
  localparam int FB      = 4;
  localparam int AW      = 5;
  localparam int ENTRIES = 17;
  localparam int HALF    = 2 ** (DW - 1);
  localparam int STEP    = 2 ** FB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sigmoid_lut_fetcher_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sigmoid_lut_fetcher #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Table answers the address driven in the current cycle; the fetcher samples it
  // at the end of that cycle. A filler value shows up when rom_en is low.
  logic [DW-1:0] rom_table [ENTRIES];
  assign bus.rom_data = bus.rom_en ? rom_table[bus.rom_addr] : 8'hEE;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".in_ready"},  bus.in_ready,  1);
    check({tag, ".rom_en"},    bus.rom_en,    0);
    check({tag, ".rom_addr"},  bus.rom_addr,  0);
    check({tag, ".out_valid"}, bus.out_valid, 0);
    check({tag, ".base"},      bus.base,      0);
    check({tag, ".next"},      bus.next_data, 0);
    check({tag, ".change"},    bus.change,    0);
    check({tag, ".remaining"}, bus.remaining, 0);
  endtask

  // Reference: idx = floor(x / 2^FB) + 2^(DW-FB-1), fraction = low FB bits.
  function automatic void model(input logic [DW-1:0] xv, output int idx,
                                output logic [DW-1:0] b, output logic [DW-1:0] n,
                                output logic [DW-1:0] c, output logic [DW-1:0] r);
    int xi;
    int d;
    xi  = int'($signed(xv));
    idx = (xi + HALF) / STEP;
    r   = DW'((xi + HALF) % STEP);
    b   = rom_table[idx];
    n   = rom_table[idx + 1];
    d   = int'(n) - int'(b);
    c   = d[DW-1:0];
  endfunction

  // Runs one transaction starting at a falling edge in IDLE; out_ready stays low
  // for 'stall' extra cycles of out_valid. in_valid stays high throughout so any
  // attempt to accept while busy would show up as extra ROM traffic.
  task automatic txn(input logic [DW-1:0] xv, input int stall, input string tag);
    int            idx;
    logic [DW-1:0] eb, en, ec, er;
    model(xv, idx, eb, en, ec, er);
    check({tag, ".idle_ready"}, bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.x         = xv;
    bus.out_ready = (stall == 0);
    @(negedge clk);
    bus.x = DW'($urandom);
    check({tag, ".rd0_en"},    bus.rom_en,    1);
    check({tag, ".rd0_addr"},  bus.rom_addr,  idx);
    check({tag, ".rd0_ready"}, bus.in_ready,  0);
    check({tag, ".rd0_valid"}, bus.out_valid, 0);
    @(negedge clk);
    check({tag, ".rd1_en"},    bus.rom_en,    1);
    check({tag, ".rd1_addr"},  bus.rom_addr,  idx + 1);
    check({tag, ".rd1_valid"}, bus.out_valid, 0);
    @(negedge clk);
    check({tag, ".out_valid"}, bus.out_valid, 1);
    check({tag, ".out_en"},    bus.rom_en,    0);
    check({tag, ".base"},      bus.base,      eb);
    check({tag, ".next"},      bus.next_data, en);
    check({tag, ".change"},    bus.change,    ec);
    check({tag, ".remaining"}, bus.remaining, er);
    for (int s = 0; s < stall; s++) begin
      bus.x = DW'($urandom);
      @(negedge clk);
      check({tag, ".hold_valid"}, bus.out_valid, 1);
      check({tag, ".hold_ready"}, bus.in_ready,  0);
      check({tag, ".hold_en"},    bus.rom_en,    0);
      check({tag, ".hold_base"},  bus.base,      eb);
      check({tag, ".hold_next"},  bus.next_data, en);
      check({tag, ".hold_chg"},   bus.change,    ec);
      check({tag, ".hold_rem"},   bus.remaining, er);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, ".done_valid"}, bus.out_valid, 0);
    check({tag, ".done_ready"}, bus.in_ready,  1);
    check({tag, ".done_en"},    bus.rom_en,    0);
    check({tag, ".kept_base"},  bus.base,      eb);
    check({tag, ".kept_chg"},   bus.change,    ec);
    check({tag, ".kept_rem"},   bus.remaining, er);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, ".idle_en"},    bus.rom_en,    0);
      check({tag, ".idle_valid"}, bus.out_valid, 0);
      check({tag, ".idle_ready"}, bus.in_ready,  1);
    end
  endtask

  initial begin
    int interp;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < ENTRIES; i++) rom_table[i] = DW'($urandom);
    rom_table[3]  = 8'h7F;
    rom_table[4]  = 8'h80;
    rom_table[8]  = 8'h40;
    rom_table[9]  = 8'h48;
    rom_table[10] = 8'h50;
    rom_table[11] = 8'h5C;

    @(negedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed corners from the table layout.
    txn(8'h00, 0, "x00");
    txn(8'h80, 0, "xmin");
    txn(8'h7F, 0, "xmax");
    txn(8'hB0, 0, "wrap_chg");
    txn(8'h2B, 10, "bp");
    interp = int'($signed(bus.base)) + ((int'($signed(bus.change)) * int'(bus.remaining)) >>> FB);
    check("interp_x2b", 32'(interp), 32'h58);
    idle_cycles(2, "gap0");

    // Back-to-back: a new accept every 4 cycles.
    for (int t = 0; t < 4; t++) txn(DW'($urandom), 0, "b2b");

    // Reset while the second ROM read is being issued.
    bus.in_valid = 1'b1;
    bus.x        = 8'h35;
    @(negedge clk);
    check("rst_rd.pre_en", bus.rom_en, 1);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_rd");
    rst = 1'b0;
    idle_cycles(3, "rst_rd_after");

    // Reset while holding operands under backpressure.
    bus.in_valid  = 1'b1;
    bus.x         = 8'hC7;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hold.pre_valid", bus.out_valid, 1);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_hold");
    rst = 1'b0;
    idle_cycles(3, "rst_hold_after");

    // Random activations over a fresh random table.
    for (int i = 0; i < ENTRIES; i++) rom_table[i] = DW'($urandom);
    for (int t = 0; t < 12; t++) begin
      idle_cycles(int'($urandom_range(0, 2)), "rnd_gap");
      txn(DW'($urandom), int'($urandom_range(0, 3)), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
